pll_reconfig_ctrl: RTL and testbench
====================================

// Module: pll_reconfig_ctrl
// PURPOSE
//  Sequencer for the Gowin rPLL dynamic input divider. Runs on the free-running 27 MHz reference clock.
//  Drives the PLL reset and IDSEL pins, synchronises and filters LOCK, and accepts divider-change requests.
//  Recovers from lock loss, retries on lock timeout, and falls back to the last-good divider.
//  Sits between the clock/reset top level and the rPLL wrapper, whose idsel input is driven from this block.
// PARAMETERS
//  IDSEL_W          6     width of divider value / IDSEL bus
//  INIT_IDIV        0     divider programmed after rst_n release
//  MAX_IDIV         63    largest legal divider; requests above it are rejected
//  IDSEL_INVERT     1     1: pll_idsel = ~div (Gowin dynamic encoding); 0: pll_idsel = div
//  RST_HOLD_CYC     16    cycles pll_reset stays high per apply
//  LOCK_STABLE_CYC  256   consecutive synced-lock-high cycles needed to declare lock
//  LOCK_TIMEOUT_CYC 65536 cycles allowed in WAIT before a timeout
//  MAX_RETRY        3     retries of the same divider before fallback
// PORTS
//  clk         in  1        27 MHz reference clock (same net as the PLL clkin)
//  rst_n       in  1        asynchronous active-low reset
//  req_valid   in  1        divider change request
//  req_ready   out 1        request accepted when req_valid && req_ready
//  req_div     in  IDSEL_W  requested divider
//  pll_lock    in  1        raw PLL LOCK, asynchronous
//  pll_reset   out 1        to PLL RESET
//  pll_idsel   out IDSEL_W  to PLL IDSEL
//  locked      out 1        filtered lock, high only in RUN
//  busy        out 1        high in any state except RUN and FAIL
//  cur_div     out IDSEL_W  divider currently applied
//  err_pulse   out 1        one-cycle pulse on reject, timeout, or fallback
//  fallback    out 1        sticky; set on fallback, cleared on the next accepted request
//  fail        out 1        sticky; last-good divider also failed
//  relock_cnt  out 16       number of APPLY entries (optional feature)
//  loss_cnt    out 16       number of lock-loss events (optional feature)
// BEHAVIOUR
//  Reset (async, rst_n=0): pll_reset=1 immediately. Other outputs:
//   - pll_idsel = enc(INIT_IDIV); cur_div = last_good = INIT_IDIV
//   - locked=0, busy=1, req_ready=0, err_pulse=0, fallback=0, fail=0
//   - counters = 0; state = APPLY
//  Lock input: pll_lock passes through a 2-FF synchroniser. lock_ok asserts once the synced lock has been high for LOCK_STABLE_CYC consecutive cycles; any low cycle clears the count.
//  States:
//   APPLY: pll_reset=1, pll_idsel=enc(target). After RST_HOLD_CYC cycles, go to WAIT with the timer cleared.
//   WAIT: pll_reset=0.
//    - lock_ok: go to RUN; last_good=target, retry=0.
//    - timer reaches LOCK_TIMEOUT_CYC-1: pulse err_pulse.
//      - retry<MAX_RETRY: retry++, go to APPLY with the same target.
//      - else if target!=last_good: target=last_good, retry=0, fallback=1, go to APPLY.
//      - else: fail=1, go to FAIL (pll_reset stays 0, PLL keeps trying freely).
//   RUN: locked=1, req_ready=1.
//    - synced lock low for 1 cycle: locked=0 the next cycle, loss_cnt++, go to APPLY with cur_div.
//    - Lock loss takes priority over a request arriving in the same cycle (the request is not accepted).
//   FAIL: req_ready=1. An accepted request clears fail and is handled as in RUN.
//  Request handling:
//   - req_div > MAX_IDIV: accepted, err_pulse, no state change.
//   - req_div == cur_div: accepted as a no-op, no PLL reset.
//   - otherwise: target=req_div, retry=0, fallback cleared, go to APPLY.
//  Request-to-pll_reset latency: 1 cycle. cur_div updates on APPLY entry.
//  Counters are sized $clog2(N+1). Event counters saturate at 16'hFFFF (no wrap).
// CONFIGURATION
//  PLL_RECONFIG_STATS_EN defined: relock_cnt and loss_cnt are live, saturating, and cleared only by rst_n.
//  Not defined: both ports are tied to 16'h0 and no counter flops are built.
// STRUCTURE
//  pll_reconfig_pkg holds:
//   - state_e {APPLY, WAIT, RUN, FAIL}
//   - the cnt_w() width function
//   - STATS_W=16
//  Sub-module pll_lock_filter: 2-FF sync plus stability counter.
//   Ports: clk, rst_n, lock_async, clr, lock_sync, lock_ok.
// TESTING
//  Use RST_HOLD_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=64, MAX_RETRY=2 for all scenarios.
//  Power-up: release rst_n, drive lock high from cycle 10.
//   -> pll_reset high for 4 cycles, pll_idsel=6'h3F, locked=1 after 8 synced-high cycles plus 2 sync cycles, busy=0.
//  Change divider: in RUN, req_div=3.
//   -> pll_reset=1 the next cycle, pll_idsel=6'h3C, cur_div=3; after relock, locked=1 and last_good=3.
//  Timeout and fallback: req_div=5 with lock held low.
//   -> 3 timeouts (3 err_pulse), then pll_idsel reverts to the last-good encoding, fallback=1, relock reaches RUN.
//  Lock loss: in RUN, drop lock for 1 cycle.
//   -> locked=0, APPLY with the same cur_div, loss_cnt=1 (with STATS_EN), and RUN again.
//  Reject and no-op:
//   - req_div=64 with IDSEL_W=7 and MAX_IDIV=63 -> err_pulse, no pll_reset.
//   - req_div=cur_div -> no err_pulse, no pll_reset.
//  Reset mid-WAIT: assert rst_n=0.
//   -> pll_reset=1 combinationally, all outputs return to reset values, and the sequence restarts at INIT_IDIV.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
// Shared types and helpers for the rPLL reconfiguration sequencer.
package pll_reconfig_pkg;

  // Width of the relock and lock-loss event counters.
  localparam int STATS_W = 16;

  // Sequencer states.
  typedef enum logic [1:0] {
    APPLY = 2'd0,
    WAIT  = 2'd1,
    RUN   = 2'd2,
    FAIL  = 2'd3
  } state_e;

  // Bits needed to hold the values 0..n (never less than one bit).
  function automatic int cnt_w(input int n);
    if (n < 1) begin
      return 1;
    end else begin
      return $clog2(n + 1);
    end
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Lock qualifier: two-flop synchroniser for the raw PLL LOCK, followed by
// a counter. lock_ok is true in the cycle that completes STABLE_CYC
// consecutive synced-high cycles, and stays true while lock holds.
module pll_lock_filter
  import pll_reconfig_pkg::*;
#(
  parameter int STABLE_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_async,
  input  logic clr,
  output logic lock_sync,
  output logic lock_ok
);

  localparam int CW = cnt_w(STABLE_CYC);
  localparam logic [CW-1:0] SAT = CW'(STABLE_CYC - 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Bring the asynchronous LOCK into the reference-clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= lock_async;
      sync_q <= meta_q;
    end
  end

  // Count consecutive synced-high cycles; a low cycle or clr restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !sync_q) begin
      cnt_d = '0;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stability counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lock_sync = sync_q;
  assign lock_ok   = sync_q && (cnt_q == SAT);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Sequencer for the Gowin rPLL dynamic input divider (IDSEL).
// Holds the PLL in reset while a new divider is applied, waits for a
// filtered lock, retries on timeout and falls back to the last divider
// that locked. Define PLL_RECONFIG_STATS_EN to build the saturating
// relock/lock-loss counters; otherwise those ports read zero.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int IDSEL_W          = 6,
  parameter int INIT_IDIV        = 0,
  parameter int MAX_IDIV         = 63,
  parameter int IDSEL_INVERT     = 1,
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [IDSEL_W-1:0] req_div,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic [IDSEL_W-1:0] pll_idsel,
  output logic               locked,
  output logic               busy,
  output logic [IDSEL_W-1:0] cur_div,
  output logic               err_pulse,
  output logic               fallback,
  output logic               fail,
  output logic [STATS_W-1:0] relock_cnt,
  output logic [STATS_W-1:0] loss_cnt
);

  // One timer serves both the reset hold and the lock timeout.
  localparam int TMR_MAX = (LOCK_TIMEOUT_CYC > RST_HOLD_CYC) ? LOCK_TIMEOUT_CYC : RST_HOLD_CYC;
  localparam int TMR_W   = cnt_w(TMR_MAX);
  localparam int RTY_W   = cnt_w(MAX_RETRY);

  localparam logic [IDSEL_W-1:0] INIT_DIV  = IDSEL_W'(INIT_IDIV);
  localparam logic [IDSEL_W:0]   MAX_DIV   = (IDSEL_W + 1)'(MAX_IDIV);
  localparam logic [TMR_W-1:0]   HOLD_LAST = TMR_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0]   TMO_LAST  = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0]   RTY_MAX   = RTY_W'(MAX_RETRY);

  // Gowin dynamic IDSEL takes the one's complement of the divider.
  function automatic logic [IDSEL_W-1:0] enc(input logic [IDSEL_W-1:0] d);
    if (IDSEL_INVERT != 0) begin
      return ~d;
    end else begin
      return d;
    end
  endfunction

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [IDSEL_W-1:0] target_q, target_d;
  logic [IDSEL_W-1:0] last_good_q, last_good_d;
  logic               fallback_q, fallback_d;
  logic               fail_q, fail_d;
  logic               err_q, err_d;
  logic               pll_reset_q, pll_reset_d;
  logic [IDSEL_W-1:0] idsel_q, idsel_d;
  logic               locked_q, locked_d;
  logic               busy_q, busy_d;
  logic               rdy_q, rdy_d;

  logic lock_sync_s;
  logic lock_ok_s;
  logic loss_s;
  logic accept_s;
  logic req_over_s;

  pll_lock_filter #(
    .STABLE_CYC (LOCK_STABLE_CYC)
  ) u_lock_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .lock_async (pll_lock),
    .clr        (state_q == APPLY),
    .lock_sync  (lock_sync_s),
    .lock_ok    (lock_ok_s)
  );

  // A lock drop in RUN wins over a request in the same cycle, so ready is
  // withdrawn combinationally from registered terms while lock is low.
  assign loss_s     = (state_q == RUN) && !lock_sync_s;
  assign req_ready  = rdy_q && !loss_s;
  assign accept_s   = req_valid && req_ready;
  assign req_over_s = ({1'b0, req_div} > MAX_DIV);

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    target_d    = target_q;
    last_good_d = last_good_q;
    fallback_d  = fallback_q;
    fail_d      = fail_q;
    err_d       = 1'b0;

    case (state_q)
      APPLY: begin
        if (timer_q == HOLD_LAST) begin
          state_d = WAIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      WAIT: begin
        if (lock_ok_s) begin
          state_d     = RUN;
          last_good_d = target_q;
          retry_d     = '0;
          timer_d     = '0;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          timer_d = '0;
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = APPLY;
          end else if (target_q != last_good_q) begin
            target_d   = last_good_q;
            retry_d    = '0;
            fallback_d = 1'b1;
            state_d    = APPLY;
          end else begin
            fail_d  = 1'b1;
            state_d = FAIL;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      RUN, FAIL: begin
        if (loss_s) begin
          state_d = APPLY;
          timer_d = '0;
        end else if (accept_s) begin
          fail_d     = 1'b0;
          fallback_d = 1'b0;
          if (req_over_s) begin
            err_d = 1'b1;
          end else if (req_div == target_q) begin
            state_d = state_q;
          end else begin
            target_d = req_div;
            retry_d  = '0;
            timer_d  = '0;
            state_d  = APPLY;
          end
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = APPLY;
        timer_d = '0;
      end
    endcase

    pll_reset_d = (state_d == APPLY);
    idsel_d     = enc(target_d);
    locked_d    = (state_d == RUN);
    busy_d      = (state_d == APPLY) || (state_d == WAIT);
    rdy_d       = (state_d == RUN) || (state_d == FAIL);
  end

  // State, bookkeeping and output registers; reset asserts pll_reset at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= APPLY;
      timer_q     <= '0;
      retry_q     <= '0;
      target_q    <= INIT_DIV;
      last_good_q <= INIT_DIV;
      fallback_q  <= 1'b0;
      fail_q      <= 1'b0;
      err_q       <= 1'b0;
      pll_reset_q <= 1'b1;
      idsel_q     <= enc(INIT_DIV);
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      target_q    <= target_d;
      last_good_q <= last_good_d;
      fallback_q  <= fallback_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
      pll_reset_q <= pll_reset_d;
      idsel_q     <= idsel_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      rdy_q       <= rdy_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign pll_idsel = idsel_q;
  assign locked    = locked_q;
  assign busy      = busy_q;
  assign cur_div   = target_q;
  assign err_pulse = err_q;
  assign fallback  = fallback_q;
  assign fail      = fail_q;

`ifdef PLL_RECONFIG_STATS_EN
  logic               enter_apply_s;
  logic [STATS_W-1:0] relock_q;
  logic [STATS_W-1:0] loss_q;

  assign enter_apply_s = (state_d == APPLY) && (state_q != APPLY);

  // Saturating event counters, cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relock_q <= '0;
      loss_q   <= '0;
    end else begin
      if (enter_apply_s && (relock_q != {STATS_W{1'b1}})) begin
        relock_q <= relock_q + 1'b1;
      end
      if (loss_s && (loss_q != {STATS_W{1'b1}})) begin
        loss_q <= loss_q + 1'b1;
      end
    end
  end

  assign relock_cnt = relock_q;
  assign loss_cnt   = loss_q;
`else
  assign relock_cnt = {STATS_W{1'b0}};
  assign loss_cnt   = {STATS_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: power-up, a table of divider
// requests, timeout/fallback, lock loss, fail and reset in the middle of WAIT.
// IDSEL_W is 7 so that a divider of 64 can be requested; the low six bits of
// every encoding match the 6-bit Gowin encoding.
module tb_pll_reconfig_ctrl;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_div = '0;
  logic         pll_lock = 1'b0;
  logic         req_ready;
  logic         pll_reset;
  logic [W-1:0] pll_idsel;
  logic         locked;
  logic         busy;
  logic [W-1:0] cur_div;
  logic         err_pulse;
  logic         fallback;
  logic         fail;
  logic [15:0]  relock_cnt;
  logic [15:0]  loss_cnt;

  int checks = 0;
  int errors = 0;
  int exp_relock = 0;

  typedef struct {
    logic [W-1:0] div;
    logic         exp_err;
    logic         exp_rst;
    logic [W-1:0] exp_cur;
  } vec_t;

  typedef struct {
    string        name;
    logic         exp_err;
    logic         exp_rst;
    logic [W-1:0] exp_cur;
  } sb_t;

  vec_t vecs[6];
  sb_t  sbq[$];

  pll_reconfig_ctrl #(
    .IDSEL_W          (W),
    .INIT_IDIV        (0),
    .MAX_IDIV         (63),
    .IDSEL_INVERT     (1),
    .RST_HOLD_CYC     (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (64),
    .MAX_RETRY        (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_div    (req_div),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_idsel  (pll_idsel),
    .locked     (locked),
    .busy       (busy),
    .cur_div    (cur_div),
    .err_pulse  (err_pulse),
    .fallback   (fallback),
    .fail       (fail),
    .relock_cnt (relock_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] enc(input logic [W-1:0] d);
    return ~d;
  endfunction

  // Counter values the bench expects, depending on whether stats are built.
  function automatic logic [31:0] stat(input int v);
`ifdef PLL_RECONFIG_STATS_EN
    return 32'(v);
`else
    return 32'd0 & 32'(v);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_locked(input string name, input int bound);
    int n = 0;
    while (locked !== 1'b1 && n < bound) begin
      cycle();
      n++;
    end
    chk(name, 32'(locked), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
    chk({tag, "_idsel"}, 32'(pll_idsel), 32'(enc(7'd0)));
    chk({tag, "_cur_div"}, 32'(cur_div), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_err"}, 32'(err_pulse), 32'd0);
    chk({tag, "_fallback"}, 32'(fallback), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_relock_cnt"}, 32'(relock_cnt), 32'd0);
    chk({tag, "_loss_cnt"}, 32'(loss_cnt), 32'd0);
  endtask

  // Hard stop in case a bounded wait is miscounted.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int n;
    int errs;
    int fb_at;
    sb_t sb;

    vecs[0] = '{7'd3,   1'b0, 1'b1, 7'd3};
    vecs[1] = '{7'd3,   1'b0, 1'b0, 7'd3};
    vecs[2] = '{7'd64,  1'b1, 1'b0, 7'd3};
    vecs[3] = '{7'd127, 1'b1, 1'b0, 7'd3};
    vecs[4] = '{7'd10,  1'b0, 1'b1, 7'd10};
    vecs[5] = '{7'd0,   1'b0, 1'b1, 7'd0};

    // Power-up.
    repeat (3) cycle();
    check_reset_vals("por");
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (pll_reset === 1'b1) hi++;
      cycle();
    end
    chk("pwrup_rst_hold", 32'(hi), 32'd4);
    chk("pwrup_idsel", 32'(pll_idsel), 32'(enc(7'd0)));
    pll_lock = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    chk("pwrup_lock_latency", 32'(n), 32'd10);
    chk("pwrup_busy", 32'(busy), 32'd0);
    chk("pwrup_cur_div", 32'(cur_div), 32'd0);

    // Table of requests issued from RUN with lock held high.
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_div   = vecs[i].div;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'd1);
      sbq.push_back('{$sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_rst, vecs[i].exp_cur});
      cycle();
      req_valid = 1'b0;
      sb = sbq.pop_front();
      chk({sb.name, "_err"}, 32'(err_pulse), 32'(sb.exp_err));
      chk({sb.name, "_pll_reset"}, 32'(pll_reset), 32'(sb.exp_rst));
      chk({sb.name, "_cur_div"}, 32'(cur_div), 32'(sb.exp_cur));
      chk({sb.name, "_idsel"}, 32'(pll_idsel), 32'(enc(sb.exp_cur)));
      cycle();
      chk({sb.name, "_err_one_shot"}, 32'(err_pulse), 32'd0);
      if (vecs[i].exp_rst) begin
        exp_relock++;
        wait_locked({sb.name, "_relock"}, 200);
      end
    end

    // Timeout, two retries, then fallback to the last good divider (0).
    req_valid = 1'b1;
    req_div   = 7'd5;
    cycle();
    req_valid = 1'b0;
    pll_lock  = 1'b0;
    chk("tmo_apply", 32'(pll_reset), 32'd1);
    chk("tmo_cur_div", 32'(cur_div), 32'd5);
    errs = 0;
    n = 0;
    while (fallback !== 1'b1 && n < 1000) begin
      if (err_pulse === 1'b1) errs++;
      cycle();
      n++;
    end
    if (err_pulse === 1'b1) errs++;
    chk("tmo_err_count", 32'(errs), 32'd3);
    chk("tmo_fallback", 32'(fallback), 32'd1);
    chk("tmo_idsel", 32'(pll_idsel), 32'(enc(7'd0)));
    chk("tmo_cur_div_fb", 32'(cur_div), 32'd0);
    chk("tmo_reapply", 32'(pll_reset), 32'd1);
    exp_relock += 4;
    pll_lock = 1'b1;
    wait_locked("fb_relock", 200);
    chk("fb_sticky", 32'(fallback), 32'd1);
    chk("fb_busy", 32'(busy), 32'd0);

    // One-cycle lock drop in RUN.
    pll_lock = 1'b0;
    cycle();
    pll_lock = 1'b1;
    n = 1;
    while (locked === 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    chk("loss_latency", 32'(n), 32'd3);
    chk("loss_apply", 32'(pll_reset), 32'd1);
    chk("loss_cur_div", 32'(cur_div), 32'd0);
    chk("loss_busy", 32'(busy), 32'd1);
    exp_relock++;
    wait_locked("loss_relock", 200);
    chk("loss_cnt", 32'(loss_cnt), stat(1));

    // New divider never locks, fallback divider never locks either: FAIL.
    req_valid = 1'b1;
    req_div   = 7'd9;
    cycle();
    req_valid = 1'b0;
    pll_lock  = 1'b0;
    chk("fail_fb_cleared", 32'(fallback), 32'd0);
    chk("fail_cur_div", 32'(cur_div), 32'd9);
    errs = 0;
    fb_at = -1;
    n = 0;
    while (fail !== 1'b1 && n < 2000) begin
      if (err_pulse === 1'b1) errs++;
      if (fallback === 1'b1 && fb_at < 0) fb_at = errs;
      cycle();
      n++;
    end
    if (err_pulse === 1'b1) errs++;
    chk("fail_fb_at", 32'(fb_at), 32'd3);
    chk("fail_err_count", 32'(errs), 32'd6);
    chk("fail_flag", 32'(fail), 32'd1);
    chk("fail_pll_reset", 32'(pll_reset), 32'd0);
    chk("fail_busy", 32'(busy), 32'd0);
    chk("fail_ready", 32'(req_ready), 32'd1);
    chk("fail_locked", 32'(locked), 32'd0);
    exp_relock += 6;
    chk("relock_cnt_a", 32'(relock_cnt), stat(exp_relock));

    // Request out of FAIL, then reset while waiting for lock.
    req_valid = 1'b1;
    req_div   = 7'd7;
    cycle();
    req_valid = 1'b0;
    chk("exit_fail_cleared", 32'(fail), 32'd0);
    chk("exit_fail_apply", 32'(pll_reset), 32'd1);
    chk("exit_fail_cur_div", 32'(cur_div), 32'd7);
    exp_relock++;
    n = 0;
    while (pll_reset === 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk("midwait_reached", 32'(pll_reset), 32'd0);
    chk("midwait_busy", 32'(busy), 32'd1);
    chk("relock_cnt_b", 32'(relock_cnt), stat(exp_relock));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midwait_rst");
    cycle();
    cycle();
    rst_n = 1'b1;
    pll_lock = 1'b1;
    wait_locked("restart_relock", 100);
    chk("restart_cur_div", 32'(cur_div), 32'd0);
    chk("restart_idsel", 32'(pll_idsel), 32'(enc(7'd0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
